// File: rtl/render_scan_gen.sv
// Raster pixel-walk generator: one frame walk per synchronized clk60 tick, gated by update_busy.
// Optional interlaced field scanning is enabled by defining RENDER_SCAN_INTERLACE_EN.
module render_scan_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clk25M,
    input  logic              reset,
    input  logic              clk60,
    input  logic              update_busy,
    input  logic              hold,
    output logic [9:0]        whpos,
    output logic [9:0]        wvpos,
    output logic [ADDR_W-1:0] write_vramA,
    output logic              write_ENA,
    output logic              scanning,
    output logic              frame_done,
    output logic [7:0]        overrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q, sync3_q;
    logic              tick_s;
    logic [9:0]        h_q, h_d, v_q, v_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [9:0]        whpos_q, whpos_d, wvpos_q, wvpos_d;
    logic [ADDR_W-1:0] vram_a_q, vram_a_d;
    logic              ena_q, ena_d;
    logic              scanning_q, scanning_d;
    logic              done_q, done_d;
    logic [7:0]        ovr_q, ovr_d;

    logic [9:0]        first_row_s, row_step_s, v_last_s;
    logic [ADDR_W-1:0] first_addr_s, wrap_step_s;

`ifdef RENDER_SCAN_INTERLACE_EN
    logic field_q, field_d;

    // A field scans every other row; the wrap step skips the row of the other field.
    assign first_row_s  = {9'd0, field_q};
    assign first_addr_s = field_q ? ADDR_W'(H_ACTIVE) : {ADDR_W{1'b0}};
    assign row_step_s   = 10'd2;
    assign wrap_step_s  = ADDR_W'(H_ACTIVE + 1);
    assign v_last_s     = 10'(V_ACTIVE - 2) + {9'd0, field_q};
    assign field_d      = (state_q == ST_DONE) ? ~field_q : field_q;
`else
    assign first_row_s  = 10'd0;
    assign first_addr_s = {ADDR_W{1'b0}};
    assign row_step_s   = 10'd1;
    assign wrap_step_s  = ADDR_W'(1);
    assign v_last_s     = 10'(V_ACTIVE - 1);
`endif

    assign tick_s = sync2_q & ~sync3_q;

    // Next-state, walk counters and registered-output values.
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        v_d      = v_q;
        addr_d   = addr_q;
        whpos_d  = whpos_q;
        wvpos_d  = wvpos_q;
        vram_a_d = vram_a_q;
        ena_d    = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!update_busy) begin
                    h_d     = 10'd0;
                    v_d     = first_row_s;
                    addr_d  = first_addr_s;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_SCAN: begin
                if (!hold) begin
                    whpos_d  = h_q;
                    wvpos_d  = v_q;
                    vram_a_d = addr_q;
                    ena_d    = 1'b1;
                    if (h_q == H_LAST) begin
                        h_d    = 10'd0;
                        v_d    = v_q + row_step_s;
                        addr_d = addr_q + wrap_step_s;
                        if (v_q == v_last_s) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_SCAN;
                        end
                    end else begin
                        h_d    = h_q + 10'd1;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else begin
                    ena_d = 1'b0;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ticks outside IDLE are dropped but counted, saturating.
        if (tick_s && (state_q != ST_IDLE) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end else begin
            ovr_d = ovr_q;
        end

        scanning_d = (state_d == ST_ARM) || (state_d == ST_SCAN);
    end

    // All state, synchronizer and output registers.
    always_ff @(posedge clk25M) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            h_q        <= 10'd0;
            v_q        <= 10'd0;
            addr_q     <= {ADDR_W{1'b0}};
            whpos_q    <= 10'd0;
            wvpos_q    <= 10'd0;
            vram_a_q   <= {ADDR_W{1'b0}};
            ena_q      <= 1'b0;
            scanning_q <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 8'd0;
`ifdef RENDER_SCAN_INTERLACE_EN
            field_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= clk60;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            h_q        <= h_d;
            v_q        <= v_d;
            addr_q     <= addr_d;
            whpos_q    <= whpos_d;
            wvpos_q    <= wvpos_d;
            vram_a_q   <= vram_a_d;
            ena_q      <= ena_d;
            scanning_q <= scanning_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
`ifdef RENDER_SCAN_INTERLACE_EN
            field_q    <= field_d;
`endif
        end
    end

    assign whpos       = whpos_q;
    assign wvpos       = wvpos_q;
    assign write_vramA = vram_a_q;
    assign write_ENA   = ena_q;
    assign scanning    = scanning_q;
    assign frame_done  = done_q;
    assign overrun_cnt = ovr_q;

endmodule
